srt_divider_hs: RTL and testbench

Parametrised radix-2 SRT integer divider with valid/ready handshakes on both sides, a passthrough tag, and C-style signed semantics: quotient truncates toward zero, remainder takes the dividend's sign. It is the next generation of the team's fixed-width SRT divider. It sits behind an issue queue in the arithmetic datapath and produces one result per operation, holding that result under back-pressure.

---
 rtl/srt_div_pkg.sv | 33 +++
 rtl/srt_div_lzc.sv | 18 +
 rtl/srt_divider_hs.sv | 223 ++++++++++++++++++++++
 tb/tb_srt_divider_hs.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srt_div_pkg.sv
// rtl/srt_div_pkg.sv - shared types and helpers for the radix-2 SRT divider
package srt_div_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE,
    NORM,
    ITER,
    FIX,
    DONE
  } state_t;

  // Redundant quotient digit {-1, 0, +1}
  typedef enum logic [1:0] {
    NEG,
    ZERO,
    POS
  } digit_t;

  // Widest operand the absolute-value helper handles
  localparam int ABS_W = 64;

  // Counter width able to hold 0..n (CNT_W = $clog2(N+1))
  function automatic int cntW(input int n);
    return $clog2(n + 1);
  endfunction

  // Two's-complement magnitude; callers zero-extend and keep the low bits
  function automatic logic [ABS_W-1:0] absVal(input logic [ABS_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/srt_div_lzc.sv
// rtl/srt_div_lzc.sv - combinational leading-zero counter, returns N for an all-zero input
module srt_div_lzc #(
  parameter int N     = 32,
  parameter int CNT_W = 6
) (
  input  logic [N-1:0]     a,
  output logic [CNT_W-1:0] count
);

  // Highest set bit wins: scan upward so later hits overwrite earlier ones
  always_comb begin
    count = CNT_W'(N);
    for (int i = 0; i < N; i++) begin
      if (a[i]) count = CNT_W'(N - 1 - i);
    end
  end

endmodule

// File: rtl/srt_divider_hs.sv
// rtl/srt_divider_hs.sv - radix-2 SRT integer divider with valid/ready handshakes; SRT_DIV_EARLY_TERM_EN enables the |x|<|y| shortcut
module srt_divider_hs
  import srt_div_pkg::*;
#(
  parameter int N     = 32,  // 4..64
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [N-1:0]     in_x,
  input  logic [N-1:0]     in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_q,
  output logic [N-1:0]     out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             out_ovf
);

  localparam int CNT_W = cntW(N);
  localparam int PW    = N + 2;  // partial remainder width, holds [-2D, 2D)

  state_t             state;
  logic [N-1:0]       xAbs;
  logic [N-1:0]       yAbs;
  logic               sx;        // dividend negative (signed mode only)
  logic               sy;        // divisor negative (signed mode only)
  logic               ovfReg;
  logic [TAG_W-1:0]   tag;
  logic [CNT_W-1:0]   lzReg;
  logic [CNT_W-1:0]   cnt;
  logic [N-1:0]       divD;      // normalised divisor, MSB set
  logic [PW-1:0]      pr;        // signed partial remainder
  logic [N-1:0]       xs;        // dividend bits still to be shifted into pr
  logic [N-1:0]       qReg;
  logic [N-1:0]       qmReg;     // always qReg - 1

  logic [CNT_W-1:0]   lz;
  logic [N-1:0]       xAbsC;
  logic [N-1:0]       yAbsC;
  logic [2*N-1:0]     xWide;
  logic [N-1:0]       xBack;
  logic [PW-1:0]      prShift;
  logic [PW-1:0]      divExt;
  logic [PW-1:0]      prNext;
  logic [N-1:0]       qNext;
  logic [N-1:0]       qmNext;
  digit_t             digit;
  logic [N-1:0]       prFix;
  logic [N-1:0]       qMag;
  logic [N-1:0]       rMag;
  logic [N-1:0]       qRes;
  logic [N-1:0]       rRes;
  logic               isMinByNeg1;

  srt_div_lzc #(.N(N), .CNT_W(CNT_W)) uLzc (
    .a     (yAbs),
    .count (lz)
  );

  // Operand magnitudes and the one overflowing signed case, evaluated at acceptance
  always_comb begin
    xAbsC       = N'(absVal(ABS_W'(in_x), in_signed & in_x[N-1]));
    yAbsC       = N'(absVal(ABS_W'(in_y), in_signed & in_y[N-1]));
    isMinByNeg1 = in_signed && (in_x == {1'b1, {(N-1){1'b0}}}) && (in_y == '1);
  end

  // Normalisation: |x|<<lz split into the initial remainder (upper half) and pending bits
  always_comb begin
    xWide = {{N{1'b0}}, xAbs} << lz;
    xBack = sx ? -xAbs : xAbs;
  end

  // Digit selection on the top three bits of 2*PR, thresholds at +/-0.5
  always_comb begin
    digit   = ZERO;
    prShift = {pr[N:0], xs[N-1]};
    divExt  = {2'b00, divD};
    if (!prShift[PW-1] && (prShift[PW-2] || prShift[PW-3])) begin
      digit = POS;
    end else if (prShift[PW-1] && !(prShift[PW-2] && prShift[PW-3])) begin
      digit = NEG;
    end
  end

  // Remainder update and on-the-fly quotient conversion
  always_comb begin
    prNext = prShift;
    qNext  = {qReg[N-2:0], 1'b0};
    qmNext = {qmReg[N-2:0], 1'b1};
    case (digit)
      POS: begin
        prNext = prShift - divExt;
        qNext  = {qReg[N-2:0], 1'b1};
        qmNext = {qReg[N-2:0], 1'b0};
      end
      NEG: begin
        prNext = prShift + divExt;
        qNext  = {qmReg[N-2:0], 1'b1};
        qmNext = {qmReg[N-2:0], 1'b0};
      end
      default: ;
    endcase
  end

  // Final correction of a negative remainder, denormalisation and sign restoration
  always_comb begin
    prFix = pr[PW-1] ? (pr[N-1:0] + divD) : pr[N-1:0];
    qMag  = pr[PW-1] ? qmReg : qReg;
    rMag  = prFix >> lzReg;
    qRes  = (sx ^ sy) ? -qMag : qMag;
    rRes  = sx ? -rMag : rMag;
  end

  // Controller and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_tag   <= '0;
      out_dbz   <= 1'b0;
      out_ovf   <= 1'b0;
      xAbs      <= '0;
      yAbs      <= '0;
      sx        <= 1'b0;
      sy        <= 1'b0;
      ovfReg    <= 1'b0;
      tag       <= '0;
      lzReg     <= '0;
      cnt       <= '0;
      divD      <= '0;
      pr        <= '0;
      xs        <= '0;
      qReg      <= '0;
      qmReg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            xAbs     <= xAbsC;
            yAbs     <= yAbsC;
            sx       <= in_signed & in_x[N-1];
            sy       <= in_signed & in_y[N-1];
            ovfReg   <= isMinByNeg1;
            tag      <= in_tag;
            in_ready <= 1'b0;
            state    <= NORM;
          end
        end
        NORM: begin
          divD  <= yAbs << lz;
          pr    <= PW'(xWide[2*N-1:N]);
          xs    <= xWide[N-1:0];
          lzReg <= lz;
          cnt   <= '0;
          qReg  <= '0;
          qmReg <= '1;
          if (yAbs == '0) begin
            out_q     <= '1;
            out_r     <= xBack;
            out_tag   <= tag;
            out_dbz   <= 1'b1;
            out_ovf   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
`ifdef SRT_DIV_EARLY_TERM_EN
          else if (xAbs < yAbs) begin
            out_q     <= '0;
            out_r     <= xBack;
            out_tag   <= tag;
            out_dbz   <= 1'b0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
`endif
          else begin
            state <= ITER;
          end
        end
        ITER: begin
          pr    <= prNext;
          xs    <= xs << 1;
          qReg  <= qNext;
          qmReg <= qmNext;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) state <= FIX;
        end
        FIX: begin
          out_q     <= qRes;
          out_r     <= rRes;
          out_tag   <= tag;
          out_dbz   <= 1'b0;
          out_ovf   <= ovfReg;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srt_divider_hs.sv
// tb/tb_srt_divider_hs.sv - directed self-checking bench for srt_divider_hs (N=32)
module tb_srt_divider_hs;

`ifdef SRT_DIV_EARLY_TERM_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 35;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
  logic [31:0] out_r;
  logic [3:0]  out_tag;
  logic        out_dbz;
  logic        out_ovf;

  int nCmp  = 0;
  int nFail = 0;

  srt_divider_hs #(.N(32), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_tag   (out_tag),
    .out_dbz   (out_dbz),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one request, wait for out_valid; lat counts edges including the acceptance edge
  task automatic runOp(input logic [31:0] x, input logic [31:0] y, input logic sgn,
                       input logic [3:0] tg, output int lat);
    in_x = x; in_y = y; in_signed = sgn; in_tag = tg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic releaseOut();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    nCmp++;
    if ({in_ready, out_valid, out_q, out_r, out_tag, out_dbz, out_ovf} !== {1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0}) begin
      nFail++;
      $display("FAIL reset: got rdy=%b vld=%b q=%h r=%h tag=%h dbz=%b ovf=%b, want rdy=1 vld=0 q=0 r=0 tag=0 dbz=0 ovf=0",
               in_ready, out_valid, out_q, out_r, out_tag, out_dbz, out_ovf);
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] vx [5] = '{32'd100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000};
    logic [31:0] vy [5] = '{32'd7,   32'd1,        32'h10,       32'd7, 32'hFFFFFFFF};
    logic [31:0] vq [5] = '{32'd14,  32'hFFFFFFFF, 32'h0FFFFFFF, 32'd1, 32'd0};
    logic [31:0] vr [5] = '{32'd2,   32'd0,        32'hF,        32'd0, 32'h80000000};
    int          vl [5] = '{35, 35, 35, 35, EARLY_LAT};
    int lat;
    for (int i = 0; i < 5; i++) begin
      runOp(vx[i], vy[i], 1'b0, 4'(i + 1), lat);
      nCmp++;
      if ({out_valid, out_q, out_r, out_dbz, out_ovf, out_tag} !== {1'b1, vq[i], vr[i], 1'b0, 1'b0, 4'(i + 1)} || lat != vl[i]) begin
        nFail++;
        $display("FAIL unsigned %h/%h: got vld=%b q=%h r=%h dbz=%b ovf=%b tag=%h lat=%0d, want vld=1 q=%h r=%h dbz=0 ovf=0 tag=%h lat=%0d",
                 vx[i], vy[i], out_valid, out_q, out_r, out_dbz, out_ovf, out_tag, lat, vq[i], vr[i], 4'(i + 1), vl[i]);
      end
      releaseOut();
    end
  endtask

  task automatic test_signed();
    logic [31:0] vx [4] = '{32'hFFFFFF9C, 32'd100,     32'hFFFFFF9C, 32'hFFFFFFF9};
    logic [31:0] vy [4] = '{32'd7,        32'hFFFFFFF9, 32'hFFFFFFF9, 32'd2};
    logic [31:0] vq [4] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14,       32'hFFFFFFFD};
    logic [31:0] vr [4] = '{32'hFFFFFFFE, 32'd2,        32'hFFFFFFFE, 32'hFFFFFFFF};
    int lat;
    for (int i = 0; i < 4; i++) begin
      runOp(vx[i], vy[i], 1'b1, 4'(i + 8), lat);
      nCmp++;
      if ({out_valid, out_q, out_r, out_dbz, out_ovf, out_tag} !== {1'b1, vq[i], vr[i], 1'b0, 1'b0, 4'(i + 8)} || lat != 35) begin
        nFail++;
        $display("FAIL signed %h/%h: got vld=%b q=%h r=%h dbz=%b ovf=%b tag=%h lat=%0d, want vld=1 q=%h r=%h dbz=0 ovf=0 tag=%h lat=35",
                 vx[i], vy[i], out_valid, out_q, out_r, out_dbz, out_ovf, out_tag, lat, vq[i], vr[i], 4'(i + 8));
      end
      releaseOut();
    end
  endtask

  task automatic test_dbz();
    logic [31:0] vx [2] = '{32'h1234, 32'hFFFFFFFB};
    logic        vs [2] = '{1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 2; i++) begin
      runOp(vx[i], 32'd0, vs[i], 4'h3, lat);
      nCmp++;
      if ({out_valid, out_q, out_r, out_dbz, out_ovf, out_tag} !== {1'b1, 32'hFFFFFFFF, vx[i], 1'b1, 1'b0, 4'h3} || lat != 2) begin
        nFail++;
        $display("FAIL dbz %h/0: got vld=%b q=%h r=%h dbz=%b ovf=%b tag=%h lat=%0d, want vld=1 q=ffffffff r=%h dbz=1 ovf=0 tag=3 lat=2",
                 vx[i], out_valid, out_q, out_r, out_dbz, out_ovf, out_tag, lat, vx[i]);
      end
      releaseOut();
    end
  endtask

  task automatic test_ovf();
    int lat;
    runOp(32'h80000000, 32'hFFFFFFFF, 1'b1, 4'h7, lat);
    nCmp++;
    if ({out_valid, out_q, out_r, out_dbz, out_ovf, out_tag} !== {1'b1, 32'h80000000, 32'd0, 1'b0, 1'b1, 4'h7} || lat != 35) begin
      nFail++;
      $display("FAIL ovf: got vld=%b q=%h r=%h dbz=%b ovf=%b tag=%h lat=%0d, want vld=1 q=80000000 r=0 dbz=0 ovf=1 tag=7 lat=35",
               out_valid, out_q, out_r, out_dbz, out_ovf, out_tag, lat);
    end
    releaseOut();
  endtask

  task automatic test_early();
    logic [31:0] vx [2] = '{32'd3, 32'hFFFFFFFD};
    logic        vs [2] = '{1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 2; i++) begin
      runOp(vx[i], 32'd10, vs[i], 4'hC, lat);
      nCmp++;
      if ({out_valid, out_q, out_r, out_dbz, out_ovf} !== {1'b1, 32'd0, vx[i], 1'b0, 1'b0} || lat != EARLY_LAT) begin
        nFail++;
        $display("FAIL early %h/10: got vld=%b q=%h r=%h dbz=%b ovf=%b lat=%0d, want vld=1 q=0 r=%h dbz=0 ovf=0 lat=%0d",
                 vx[i], out_valid, out_q, out_r, out_dbz, out_ovf, lat, vx[i], EARLY_LAT);
      end
      releaseOut();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    runOp(32'd1000, 32'd3, 1'b0, 4'hA, lat);
    for (int c = 0; c < 10; c++) begin
      nCmp++;
      if ({out_valid, in_ready, out_q, out_r, out_tag, out_dbz, out_ovf} !== {1'b1, 1'b0, 32'd333, 32'd1, 4'hA, 1'b0, 1'b0}) begin
        nFail++;
        $display("FAIL backpressure cycle %0d: got vld=%b rdy=%b q=%h r=%h tag=%h dbz=%b ovf=%b, want vld=1 rdy=0 q=14d r=1 tag=a dbz=0 ovf=0",
                 c, out_valid, in_ready, out_q, out_r, out_tag, out_dbz, out_ovf);
      end
      @(posedge clk); #1;
    end
    releaseOut();
    nCmp++;
    if ({out_valid, in_ready, out_q, out_tag} !== {1'b0, 1'b1, 32'd333, 4'hA}) begin
      nFail++;
      $display("FAIL backpressure release: got vld=%b rdy=%b q=%h tag=%h, want vld=0 rdy=1 q=14d tag=a",
               out_valid, in_ready, out_q, out_tag);
    end
  endtask

  task automatic test_back_to_back();
    int  cnt;
    bit  gotA;
    out_ready = 1'b1;
    in_x = 32'hDEADBEEF; in_y = 32'h1000; in_signed = 1'b0; in_tag = 4'h5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_x = 32'hFFFFFFF9; in_y = 32'd2; in_signed = 1'b1; in_tag = 4'h6;
    cnt  = 0;
    gotA = 1'b0;
    while (in_ready !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
      if (out_valid === 1'b1) begin
        gotA = 1'b1;
        nCmp++;
        if ({out_q, out_r, out_tag} !== {32'h000DEADB, 32'h00000EEF, 4'h5}) begin
          nFail++;
          $display("FAIL b2b first: got q=%h r=%h tag=%h, want q=000deadb r=00000eef tag=5", out_q, out_r, out_tag);
        end
      end
    end
    @(posedge clk); #1;
    cnt++;
    in_valid = 1'b0;
    nCmp++;
    if (gotA !== 1'b1 || cnt != 36 || in_ready !== 1'b0) begin
      nFail++;
      $display("FAIL b2b throughput: got seen=%b interval=%0d rdy=%b, want seen=1 interval=36 rdy=0", gotA, cnt, in_ready);
    end
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    nCmp++;
    if ({out_valid, out_q, out_r, out_tag} !== {1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'h6}) begin
      nFail++;
      $display("FAIL b2b second: got vld=%b q=%h r=%h tag=%h, want vld=1 q=fffffffd r=ffffffff tag=6",
               out_valid, out_q, out_r, out_tag);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    in_x = 32'd100; in_y = 32'd7; in_signed = 1'b0; in_tag = 4'h9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    nCmp++;
    if ({in_ready, out_valid, out_q, out_r, out_tag, out_dbz, out_ovf} !== {1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0}) begin
      nFail++;
      $display("FAIL reset_mid: got rdy=%b vld=%b q=%h r=%h tag=%h dbz=%b ovf=%b, want rdy=1 vld=0 all zero",
               in_ready, out_valid, out_q, out_r, out_tag, out_dbz, out_ovf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    runOp(32'd50, 32'd6, 1'b0, 4'h4, lat);
    nCmp++;
    if ({out_valid, out_q, out_r, out_tag} !== {1'b1, 32'd8, 32'd2, 4'h4} || lat != 35) begin
      nFail++;
      $display("FAIL reset_recover: got vld=%b q=%h r=%h tag=%h lat=%0d, want vld=1 q=8 r=2 tag=4 lat=35",
               out_valid, out_q, out_r, out_tag, lat);
    end
    releaseOut();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_unsigned();
    test_signed();
    test_dbz();
    test_ovf();
    test_early();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
